id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage of the pipelined LC-3b datapath. It registers the decoded control word, operands and immediate from ID into the EX-side latch. It detects load-use hazards against the instruction currently in EX and inserts bubbles: one bubble for LDR/LDB, two for LDI. It honours the downstream memory stall and the branch/trap flush, and drives the stall back to fetch/ID.

## Interface
- No parameters; widths come from `lc3b_types`.
- `clk` in 1: pipeline clock.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: ID holds a real instruction.
- `id_ctrl` in `lc3b_control_word`: control word produced by the decode logic for the ID instruction.
- `id_pc` in 16: PC+2 of the ID instruction.
- `id_sr1`, `id_sr2`, `id_dest` in 3 each: source and destination register numbers. For stores, `id_sr2` is the store-source register.
- `id_sr1_data`, `id_sr2_data`, `id_imm` in 16 each: regfile read data and sign/zero-extended immediate.
- `mem_stall` in 1: MEM stage busy (cache miss); freezes this stage.
- `flush` in 1: taken branch/JMP/JSR/TRAP resolved downstream; kills ID and EX contents.
- `ex_valid` out 1; `ex_ctrl` out `lc3b_control_word`; `ex_pc`, `ex_sr1_data`, `ex_sr2_data`, `ex_imm` out 16; `ex_dest` out 3: the EX latch.
- `id_stall` out 1: hold PC and IF/ID register this cycle (combinational).

## Operation
**States:** RUN and HOLD, plus a 2-bit `hold_cnt`.

**Load-use hazard (`luh`)** is true when all of the following hold:
- `id_valid` and `ex_valid`
- `ex_ctrl.read & ex_ctrl.load_regfile`
- a used source matches `ex_dest`: either `id_ctrl.use_op[1]` and `id_sr1==ex_dest`, or `id_ctrl.use_op[0]` and `id_sr2==ex_dest`.

**Bubble** means `ex_valid=0` and `ex_ctrl` set to all zeros. All enables (`load_regfile`, `load_cc`, `read`, `write`, `indirect_rw`) are therefore cleared. Data fields hold don't-care values; they are driven with ID data.

**Priority each cycle:** reset > flush > mem_stall > HOLD > luh > normal advance.
- **flush:** load a bubble, go to RUN, set `hold_cnt=0`, `id_stall=0`.
- **mem_stall:** EX latch, state and `hold_cnt` all hold; `id_stall=1`.
- **HOLD:** load a bubble, `id_stall=1`, decrement `hold_cnt`. Go to RUN when `hold_cnt` reaches 0.
- **RUN with luh:** load a bubble, `id_stall=1`. If `ex_ctrl.indirect_rw` is set, go to HOLD with `hold_cnt=1`; otherwise stay in RUN.
- **RUN otherwise:** latch all `id_*` fields; `ex_valid<=id_valid`; `id_stall=0`.

A bubble in EX never matches, so no hazard is re-detected after the hold ends. Forwarding from MEM/WB is handled outside this block.

## Timing
- ID→EX latency is 1 cycle.
- `id_stall` is combinational from the registered state, `ex_*`, `id_*`, `mem_stall` and `flush`.
- Reset values:
  - `ex_valid=0`, `ex_ctrl=0`
  - `ex_pc`, `ex_sr1_data`, `ex_sr2_data`, `ex_imm` = 0; `ex_dest` = 0
  - state RUN, `hold_cnt=0`
  - `id_stall=0` unless `mem_stall` is asserted.
- Bubbles per hazard: LDR/LDB give exactly 1; LDI gives exactly 2 consecutive bubbles. A `mem_stall` inside the window stretches it without changing the bubble count.
- A flush during HOLD aborts the remaining bubbles.
- A flush together with `mem_stall` still kills the EX latch.
- Reset mid-hold returns to RUN immediately.
- `id_valid=0` loads a bubble and never raises luh.

## Configuration
- **`ID_EX_HAZARD_STATS_EN` defined:**
  - Adds outputs `stat_bubbles` 16 and `stat_flushes` 16. Both are saturating at 0xFFFF and cleared by reset.
  - `stat_bubbles` increments on every cycle a bubble is loaded due to luh or HOLD.
  - `stat_flushes` increments on every cycle `flush=1`.
- **Macro undefined:** these ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Add `lc3b_reg` (3-bit) and `lc3b_word` (16-bit) typedefs to `lc3b_types` if they are absent. Also add an `id_ex_state` enum {RUN, HOLD}.
- Bubble constant `CTRL_NOP` (all-zero `lc3b_control_word`) also lives in the package.
- One sub-module: `load_use_detect`, a combinational luh comparator that also outputs the bubble count (1/2).

## Test plan
- ADD R1,R2,R3 then AND R4,R1,#5 with no loads → EX receives both on consecutive cycles, `id_stall` never asserts.
- LDR R1,R2,#0 then ADD R3,R1,R4 → one bubble (`ex_valid=0`, `ex_ctrl=0`), `id_stall=1` for 1 cycle, ADD enters EX 2 cycles after LDR.
- LDI R5,R0,#1 then STR R5,R6,#0 (store source R5) → exactly 2 bubbles, `id_stall` high 2 cycles.
- LDI hazard with `mem_stall=1` for 3 cycles during HOLD → EX latch frozen, still exactly 2 bubbles total, then STR advances.
- Flush asserted during the LDI HOLD cycle → EX bubble, state RUN, `id_stall=0` in that cycle.
- LDB R2 then NOT R3,R2 with reset pulsed in the bubble cycle → all outputs zero next cycle; with `ID_EX_HAZARD_STATS_EN`, `stat_bubbles` reads 0 after reset.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// lc3b_types: shared LC-3b datapath types used by the ID/EX stage slice.
//   lc3b_reg          3-bit register number
//   lc3b_word         16-bit datapath word
//   lc3b_control_word decoded control word carried down the pipeline
//   id_ex_state       hazard controller state (RUN / HOLD)
//   CTRL_NOP          all-zero control word used as a bubble
package lc3b_types;

  typedef logic [2:0]  lc3b_reg;
  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_opcode;

  // use_op[1] : sr1 is read by the instruction
  // use_op[0] : sr2 is read (store source for STR/STB/STI)
  typedef struct packed {
    lc3b_opcode  opcode;
    logic [2:0]  aluop;
    logic [1:0]  use_op;
    logic        load_regfile;
    logic        load_cc;
    logic        read;
    logic        write;
    logic        indirect_rw;
  } lc3b_control_word;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } id_ex_state;

  localparam lc3b_control_word CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_if: ID-side inputs, downstream control and EX latch outputs of the
// ID/EX stage.
//   master : drives id_* fields, mem_stall, flush; observes ex_* and id_stall
//   slave  : the stage itself
interface id_ex_if;
  import lc3b_types::*;

  logic             id_valid;
  lc3b_control_word id_ctrl;
  lc3b_word         id_pc;
  lc3b_reg          id_sr1;
  lc3b_reg          id_sr2;
  lc3b_reg          id_dest;
  lc3b_word         id_sr1_data;
  lc3b_word         id_sr2_data;
  lc3b_word         id_imm;
  logic             mem_stall;
  logic             flush;

  logic             ex_valid;
  lc3b_control_word ex_ctrl;
  lc3b_word         ex_pc;
  lc3b_word         ex_sr1_data;
  lc3b_word         ex_sr2_data;
  lc3b_word         ex_imm;
  lc3b_reg          ex_dest;
  logic             id_stall;

  modport master (
    output id_valid, id_ctrl, id_pc, id_sr1, id_sr2, id_dest,
           id_sr1_data, id_sr2_data, id_imm, mem_stall, flush,
    input  ex_valid, ex_ctrl, ex_pc, ex_sr1_data, ex_sr2_data, ex_imm,
           ex_dest, id_stall
  );

  modport slave (
    input  id_valid, id_ctrl, id_pc, id_sr1, id_sr2, id_dest,
           id_sr1_data, id_sr2_data, id_imm, mem_stall, flush,
    output ex_valid, ex_ctrl, ex_pc, ex_sr1_data, ex_sr2_data, ex_imm,
           ex_dest, id_stall
  );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: combinational load-use hazard comparator.
//   id_valid, id_ctrl, id_sr1, id_sr2 : instruction in ID
//   ex_valid, ex_ctrl, ex_dest        : instruction in EX
//   luh     : ID reads a register the load in EX has not yet produced
//   bubbles : bubbles the hazard costs (2 for indirect loads, else 1)
module load_use_detect
  import lc3b_types::*;
(
  input  logic             id_valid,
  input  lc3b_control_word id_ctrl,
  input  lc3b_reg          id_sr1,
  input  lc3b_reg          id_sr2,
  input  logic             ex_valid,
  input  lc3b_control_word ex_ctrl,
  input  lc3b_reg          ex_dest,
  output logic             luh,
  output logic [1:0]       bubbles
);

  logic src_match;
  logic ex_is_load;

  assign src_match  = (id_ctrl.use_op[1] && (id_sr1 == ex_dest)) ||
                      (id_ctrl.use_op[0] && (id_sr2 == ex_dest));
  assign ex_is_load = ex_ctrl.read && ex_ctrl.load_regfile;
  assign luh        = id_valid && ex_valid && ex_is_load && src_match;
  assign bubbles    = ex_ctrl.indirect_rw ? 2'd2 : 2'd1;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID -> EX pipeline latch with load-use bubble insertion.
//   clk, reset : clock, synchronous active-high reset
//   bus        : id_ex_if.slave (ID fields in, EX latch out, mem_stall,
//                flush in, id_stall out)
// Optional build macro ID_EX_HAZARD_STATS_EN adds saturating counters
//   stat_bubbles (hazard bubbles loaded) and stat_flushes (flush cycles).
module id_ex_stage
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         reset,
  id_ex_if.slave       bus
`ifdef ID_EX_HAZARD_STATS_EN
  ,
  output logic [15:0]  stat_bubbles,
  output logic [15:0]  stat_flushes
`endif
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  id_ex_state       state_p0;
  logic [1:0]       hold_cnt_p0;

  logic             ex_valid_p1;
  lc3b_control_word ex_ctrl_p1;
  lc3b_word         ex_pc_p1;
  lc3b_word         ex_sr1_data_p1;
  lc3b_word         ex_sr2_data_p1;
  lc3b_word         ex_imm_p1;
  lc3b_reg          ex_dest_p1;

  logic             luh;
  logic [1:0]       bubbles;

  logic             load_bubble;
  logic             load_id;
  logic             hazard_bubble;
  logic             stall;

  load_use_detect u_luh (
    .id_valid (bus.id_valid),
    .id_ctrl  (bus.id_ctrl),
    .id_sr1   (bus.id_sr1),
    .id_sr2   (bus.id_sr2),
    .ex_valid (ex_valid_p1),
    .ex_ctrl  (ex_ctrl_p1),
    .ex_dest  (ex_dest_p1),
    .luh      (luh),
    .bubbles  (bubbles)
  );

  // Per-cycle action, in priority order flush > mem_stall > HOLD > luh.
  always_comb begin
    load_bubble   = 1'b0;
    load_id       = 1'b0;
    hazard_bubble = 1'b0;
    stall         = 1'b0;
    if (bus.flush) begin
      load_bubble = 1'b1;
    end else if (bus.mem_stall) begin
      stall = 1'b1;
    end else if (state_p0 == HOLD || luh) begin
      load_bubble   = 1'b1;
      hazard_bubble = 1'b1;
      stall         = 1'b1;
    end else begin
      load_id = 1'b1;
    end
  end

  // ---- ID -> EX boundary: control half of the latch ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0    <= RUN;
      hold_cnt_p0 <= 2'd0;
      ex_valid_p1 <= 1'b0;
      ex_ctrl_p1  <= CTRL_NOP;
    end else if (bus.flush) begin
      state_p0    <= RUN;
      hold_cnt_p0 <= 2'd0;
      ex_valid_p1 <= 1'b0;
      ex_ctrl_p1  <= CTRL_NOP;
    end else if (bus.mem_stall) begin
      state_p0    <= state_p0;
      hold_cnt_p0 <= hold_cnt_p0;
    end else if (state_p0 == HOLD) begin
      ex_valid_p1 <= 1'b0;
      ex_ctrl_p1  <= CTRL_NOP;
      // Leaving HOLD once the count would reach zero; a stray zero count
      // also exits rather than wrapping.
      if (hold_cnt_p0 <= 2'd1) begin
        hold_cnt_p0 <= 2'd0;
        state_p0    <= RUN;
      end else begin
        hold_cnt_p0 <= hold_cnt_p0 - 2'd1;
      end
    end else if (luh) begin
      ex_valid_p1 <= 1'b0;
      ex_ctrl_p1  <= CTRL_NOP;
      // The luh cycle is the first bubble; HOLD supplies the rest.
      if (bubbles > 2'd1) begin
        state_p0    <= HOLD;
        hold_cnt_p0 <= bubbles - 2'd1;
      end
    end else begin
      ex_valid_p1 <= bus.id_valid;
      ex_ctrl_p1  <= bus.id_valid ? bus.id_ctrl : CTRL_NOP;
    end
  end

  // ---- ID -> EX boundary: data half of the latch ----
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_pc_p1       <= '0;
      ex_sr1_data_p1 <= '0;
      ex_sr2_data_p1 <= '0;
      ex_imm_p1      <= '0;
      ex_dest_p1     <= '0;
    end else if (load_bubble || load_id) begin
      ex_pc_p1       <= bus.id_pc;
      ex_sr1_data_p1 <= bus.id_sr1_data;
      ex_sr2_data_p1 <= bus.id_sr2_data;
      ex_imm_p1      <= bus.id_imm;
      ex_dest_p1     <= bus.id_dest;
    end
  end

`ifdef ID_EX_HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_bubbles <= 16'd0;
      stat_flushes <= 16'd0;
    end else begin
      if (hazard_bubble) stat_bubbles <= sat_inc16(stat_bubbles);
      if (bus.flush)     stat_flushes <= sat_inc16(stat_flushes);
    end
  end
`endif

  assign bus.ex_valid    = ex_valid_p1;
  assign bus.ex_ctrl     = ex_ctrl_p1;
  assign bus.ex_pc       = ex_pc_p1;
  assign bus.ex_sr1_data = ex_sr1_data_p1;
  assign bus.ex_sr2_data = ex_sr2_data_p1;
  assign bus.ex_imm      = ex_imm_p1;
  assign bus.ex_dest     = ex_dest_p1;
  assign bus.id_stall    = stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scoreboard bench for id_ex_stage.
module tb_id_ex_stage;
  import lc3b_types::*;

  logic clk;
  logic reset;
  id_ex_if bus ();

`ifdef ID_EX_HAZARD_STATS_EN
  logic [15:0] stat_bubbles;
  logic [15:0] stat_flushes;
`endif

  id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ID_EX_HAZARD_STATS_EN
    ,
    .stat_bubbles (stat_bubbles),
    .stat_flushes (stat_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             v;
    lc3b_control_word c;
    lc3b_word         pc;
    lc3b_reg          sr1;
    lc3b_reg          sr2;
    lc3b_reg          dest;
    lc3b_word         d1;
    lc3b_word         d2;
    lc3b_word         imm;
  } insn_t;

  typedef struct {
    logic             v;
    lc3b_control_word c;
    lc3b_word         pc;
    lc3b_word         d1;
    lc3b_word         d2;
    lc3b_word         imm;
    lc3b_reg          dest;
    logic             chk;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   tests;
  int   fails;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic lc3b_control_word mk(input logic [3:0] op, input logic [1:0] uo,
                                          input logic lr, input logic lcc, input logic rd,
                                          input logic wr, input logic ind);
    lc3b_control_word c;
    c = '0;
    c.opcode = op; c.use_op = uo; c.load_regfile = lr; c.load_cc = lcc;
    c.read = rd; c.write = wr; c.indirect_rw = ind;
    return c;
  endfunction

  function automatic insn_t ins(input lc3b_control_word c, input lc3b_word pc,
                                input lc3b_reg sr1, input lc3b_reg sr2, input lc3b_reg dest,
                                input lc3b_word d1, input lc3b_word d2, input lc3b_word imm);
    insn_t i;
    i.v = 1'b1; i.c = c; i.pc = pc; i.sr1 = sr1; i.sr2 = sr2; i.dest = dest;
    i.d1 = d1; i.d2 = d2; i.imm = imm;
    return i;
  endfunction

  function automatic exp_t ex_of(input insn_t i);
    exp_t e;
    e.v = 1'b1; e.c = i.c; e.pc = i.pc; e.d1 = i.d1; e.d2 = i.d2;
    e.imm = i.imm; e.dest = i.dest; e.chk = 1'b1;
    return e;
  endfunction

  function automatic exp_t bub();
    exp_t e;
    e.v = 1'b0; e.c = '0; e.pc = '0; e.d1 = '0; e.d2 = '0; e.imm = '0;
    e.dest = '0; e.chk = 1'b0;
    return e;
  endfunction

  function automatic exp_t zero();
    exp_t e;
    e = bub();
    e.chk = 1'b1;
    return e;
  endfunction

  // Drive one cycle of ID inputs, check id_stall before the edge, then
  // compare the EX latch after the edge against the pushed expectation.
  task automatic step(input string nm, input insn_t in, input logic ms, input logic fl,
                      input logic rs, input logic xs, input exp_t e);
    exp_t got_e;
    bus.id_valid    = in.v;
    bus.id_ctrl     = in.c;
    bus.id_pc       = in.pc;
    bus.id_sr1      = in.sr1;
    bus.id_sr2      = in.sr2;
    bus.id_dest     = in.dest;
    bus.id_sr1_data = in.d1;
    bus.id_sr2_data = in.d2;
    bus.id_imm      = in.imm;
    bus.mem_stall   = ms;
    bus.flush       = fl;
    reset           = rs;
    #1;
    check_eq({nm, ".id_stall"}, 32'(bus.id_stall), 32'(xs));
    sb.push_back(e);
    @(posedge clk);
    #1;
    got_e = sb.pop_front();
    check_eq({nm, ".ex_valid"}, 32'(bus.ex_valid), 32'(got_e.v));
    check_eq({nm, ".ex_ctrl"}, 32'(bus.ex_ctrl), 32'(got_e.c));
    if (got_e.chk) begin
      check_eq({nm, ".ex_pc"}, 32'(bus.ex_pc), 32'(got_e.pc));
      check_eq({nm, ".ex_sr1_data"}, 32'(bus.ex_sr1_data), 32'(got_e.d1));
      check_eq({nm, ".ex_sr2_data"}, 32'(bus.ex_sr2_data), 32'(got_e.d2));
      check_eq({nm, ".ex_imm"}, 32'(bus.ex_imm), 32'(got_e.imm));
      check_eq({nm, ".ex_dest"}, 32'(bus.ex_dest), 32'(got_e.dest));
    end
    last = got_e;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    lc3b_control_word c_add, c_and, c_ldr, c_ldb, c_ldi, c_str, c_not;
    insn_t nop, i_add, i_and, i_ldr, i_add2, i_ldi, i_str, i_add3, i_ldb, i_not;
`ifdef ID_EX_HAZARD_STATS_EN
    logic [15:0] sb0;
`endif
    tests = 0;
    fails = 0;

    c_add = mk(4'h1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    c_and = mk(4'h5, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    c_ldr = mk(4'h6, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    c_ldb = mk(4'h2, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    c_ldi = mk(4'hA, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    c_str = mk(4'h7, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    c_not = mk(4'h9, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    nop    = ins('0, 16'h1111, 3'd0, 3'd0, 3'd0, 16'h2222, 16'h3333, 16'h4444);
    nop.v  = 1'b0;
    i_add  = ins(c_add, 16'h3002, 3'd2, 3'd3, 3'd1, 16'h0A02, 16'h0B03, 16'h0000);
    i_and  = ins(c_and, 16'h3004, 3'd1, 3'd0, 3'd4, 16'h0C01, 16'h0000, 16'h0005);
    i_ldr  = ins(c_ldr, 16'h3010, 3'd2, 3'd0, 3'd1, 16'h4000, 16'h0000, 16'h0000);
    i_add2 = ins(c_add, 16'h3012, 3'd1, 3'd4, 3'd3, 16'h1234, 16'h5678, 16'h0000);
    i_ldi  = ins(c_ldi, 16'h3020, 3'd0, 3'd0, 3'd5, 16'h5000, 16'h0000, 16'h0002);
    i_str  = ins(c_str, 16'h3022, 3'd6, 3'd5, 3'd0, 16'h6000, 16'hBEEF, 16'h0000);
    i_add3 = ins(c_add, 16'h4000, 3'd7, 3'd7, 3'd2, 16'h7777, 16'h8888, 16'h0000);
    i_ldb  = ins(c_ldb, 16'h3030, 3'd4, 3'd0, 3'd2, 16'h9000, 16'h0000, 16'h0003);
    i_not  = ins(c_not, 16'h3032, 3'd2, 3'd0, 3'd3, 16'hA5A5, 16'h0000, 16'hFFFF);

    reset = 1'b1;
    bus.id_valid = 1'b0; bus.id_ctrl = '0; bus.id_pc = '0; bus.id_sr1 = '0;
    bus.id_sr2 = '0; bus.id_dest = '0; bus.id_sr1_data = '0; bus.id_sr2_data = '0;
    bus.id_imm = '0; bus.mem_stall = 1'b0; bus.flush = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);

    // Reset state, and mem_stall still reported while in reset
    step("rst",    nop, 1'b0, 1'b0, 1'b1, 1'b0, zero());
    step("rst_ms", nop, 1'b1, 1'b0, 1'b1, 1'b1, zero());

    // Independent ALU ops flow back to back
    step("t1_add",  i_add, 1'b0, 1'b0, 1'b0, 1'b0, ex_of(i_add));
    step("t1_and",  i_and, 1'b0, 1'b0, 1'b0, 1'b0, ex_of(i_and));
    step("t1_idle", nop,   1'b0, 1'b0, 1'b0, 1'b0, bub());

    // LDR -> dependent ADD: one bubble
    step("t2_ldr",  i_ldr,  1'b0, 1'b0, 1'b0, 1'b0, ex_of(i_ldr));
    step("t2_haz",  i_add2, 1'b0, 1'b0, 1'b0, 1'b1, bub());
    step("t2_adv",  i_add2, 1'b0, 1'b0, 1'b0, 1'b0, ex_of(i_add2));
    step("t2_idle", nop,    1'b0, 1'b0, 1'b0, 1'b0, bub());

    // LDI -> STR using R5 as store source: two bubbles
    step("t3_ldi",  i_ldi, 1'b0, 1'b0, 1'b0, 1'b0, ex_of(i_ldi));
    step("t3_b1",   i_str, 1'b0, 1'b0, 1'b0, 1'b1, bub());
    step("t3_b2",   i_str, 1'b0, 1'b0, 1'b0, 1'b1, bub());
    step("t3_adv",  i_str, 1'b0, 1'b0, 1'b0, 1'b0, ex_of(i_str));
    step("t3_idle", nop,   1'b0, 1'b0, 1'b0, 1'b0, bub());

    // LDI hazard with mem_stall both before and during HOLD
`ifdef ID_EX_HAZARD_STATS_EN
    sb0 = stat_bubbles;
`endif
    step("t4_ldi",  i_ldi, 1'b0, 1'b0, 1'b0, 1'b0, ex_of(i_ldi));
    step("t4_fz0",  i_str, 1'b1, 1'b0, 1'b0, 1'b1, last);
    step("t4_b1",   i_str, 1'b0, 1'b0, 1'b0, 1'b1, bub());
    for (int k = 0; k < 3; k++)
      step("t4_fz",  i_str, 1'b1, 1'b0, 1'b0, 1'b1, last);
    step("t4_b2",   i_str, 1'b0, 1'b0, 1'b0, 1'b1, bub());
    step("t4_adv",  i_str, 1'b0, 1'b0, 1'b0, 1'b0, ex_of(i_str));
`ifdef ID_EX_HAZARD_STATS_EN
    check_eq("t4_stat_bubbles", 32'(stat_bubbles - sb0), 32'd2);
`endif
    step("t4_idle", nop,   1'b0, 1'b0, 1'b0, 1'b0, bub());

    // Flush in the HOLD cycle aborts the second bubble
    step("t5_ldi",   i_ldi,  1'b0, 1'b0, 1'b0, 1'b0, ex_of(i_ldi));
    step("t5_b1",    i_str,  1'b0, 1'b0, 1'b0, 1'b1, bub());
    step("t5_flush", i_str,  1'b0, 1'b1, 1'b0, 1'b0, bub());
    step("t5_run",   i_add3, 1'b0, 1'b0, 1'b0, 1'b0, ex_of(i_add3));
    // Flush together with mem_stall still kills a valid EX latch
    step("t5_fms",   i_and,  1'b1, 1'b1, 1'b0, 1'b0, bub());
    step("t5_idle",  nop,    1'b0, 1'b0, 1'b0, 1'b0, bub());

    // LDB -> NOT with reset in the bubble cycle
    step("t6_ldb",  i_ldb, 1'b0, 1'b0, 1'b0, 1'b0, ex_of(i_ldb));
    step("t6_haz",  i_not, 1'b0, 1'b0, 1'b0, 1'b1, bub());
    step("t6_rst",  i_not, 1'b0, 1'b0, 1'b1, 1'b0, zero());
`ifdef ID_EX_HAZARD_STATS_EN
    check_eq("t6_stat_bubbles", 32'(stat_bubbles), 32'd0);
    check_eq("t6_stat_flushes", 32'(stat_flushes), 32'd0);
`endif
    step("t6_adv",  i_not, 1'b0, 1'b0, 1'b0, 1'b0, ex_of(i_not));

    // Reset during HOLD returns straight to RUN
    step("t7_ldi",  i_ldi, 1'b0, 1'b0, 1'b0, 1'b0, ex_of(i_ldi));
    step("t7_b1",   i_str, 1'b0, 1'b0, 1'b0, 1'b1, bub());
    step("t7_rst",  i_str, 1'b0, 1'b0, 1'b1, 1'b1, zero());
    step("t7_run",  i_str, 1'b0, 1'b0, 1'b0, 1'b0, ex_of(i_str));
    step("t7_idle", nop,   1'b0, 1'b0, 1'b0, 1'b0, bub());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
